uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: default line timing,
// counter width and the receiver state encoding.
package uart_pkg;

  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_BAUD     = 9600;
  localparam int CNT_W        = 14;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  // Both link ends derive clocks-per-bit from here so their bit periods agree.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; resets to all ones
// so an idle-high line does not present a spurious falling edge after reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= '1;
      q        <= '1;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver: start-bit validation at mid-bit, centre sampling of data
// and stop bits. Define UART_RX_PARITY_EN for an even-parity bit before the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int BIT_CNT  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             rx_s;
  logic             rx_s_d;
  logic             start_edge;
  rx_state_t        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       idx_reg;
  logic [7:0]       shift_reg;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_reg;
`endif

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk (CLOCK),
    .rst (RESET),
    .d   (rx),
    .q   (rx_s)
  );

  assign start_edge = rx_s_d & ~rx_s;
  assign rx_busy    = (state_reg != IDLE);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rx_s_d      <= 1'b1;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      shift_reg   <= '0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
      par_bad_reg <= 1'b0;
`endif
    end else begin
      rx_s_d    <= rx_s;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (start_edge) state_reg <= START;
        end
        START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            // A line already high again at mid-start is a glitch, not a frame.
            state_reg <= rx_s ? IDLE : DATA;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg            <= '0;
            shift_reg[idx_reg] <= rx_s;
            idx_reg            <= idx_reg + 3'd1;
            if (idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg     <= '0;
            par_bad_reg <= rx_s ^ (^shift_reg);
            state_reg   <= STOP;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
`endif
        STOP: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg <= '0;
            if (!rx_s) begin
              // Framing error outranks parity; wait out a break before rearming.
              frame_err <= 1'b1;
              state_reg <= WAIT_HIGH;
            end else begin
              state_reg <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad_reg) begin
                parity_err <= 1'b1;
              end else begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
              end
`else
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
`endif
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          cnt_reg <= '0;
          if (rx_s) state_reg <= IDLE;
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at BIT_CNT=10: stimulus pushes expected events,
// a negedge monitor pops and checks kind, data, spacing and latency.
module tb_uart_rx;

  localparam int BITC = 10;
  localparam int LAT  = 99;

  localparam logic [1:0] K_VALID = 2'd1;
  localparam logic [1:0] K_FERR  = 2'd2;
  localparam logic [1:0] K_PERR  = 2'd3;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] data;
    int         gap;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       RESET;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   start_cyc = 0;
  int   last_evt  = 0;
  exp_t q[$];

  uart_rx #(.CLK_FREQ(1000000), .BAUD(100000)) dut (
    .CLOCK      (clk),
    .RESET      (RESET),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: every output pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] k;
    if (!RESET && (rx_valid || frame_err || parity_err)) begin
      check("pulse_exclusive", int'(rx_valid) + int'(frame_err) + int'(parity_err), 1);
      k = rx_valid ? K_VALID : (frame_err ? K_FERR : K_PERR);
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got kind %0d data %0h, expected no pulse", k, rx_data);
      end else begin
        e = q.pop_front();
        check("pulse_kind", int'(k), int'(e.kind));
        check("pulse_data", int'(rx_data), int'(e.data));
        if (e.gap != 0) check("pulse_gap", cyc - last_evt, e.gap);
        if (e.lat != 0)
          check("pulse_latency_in_window",
                int'((cyc - start_cyc >= e.lat - 1) && (cyc - start_cyc <= e.lat + 1)), 1);
      end
      last_evt = cyc;
    end
  end

  // All stimulus tasks start and end #1 after a rising edge.
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BITC) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input bit use_par, input logic par_bit);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (use_par) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  task automatic expect_evt(input logic [1:0] kind, input logic [7:0] d,
                            input int gap, input int lat);
    exp_t e;
    e.kind = kind;
    e.data = d;
    e.gap  = gap;
    e.lat  = lat;
    q.push_back(e);
  endtask

  initial begin
    bit par;
    int extra;
`ifdef UART_RX_PARITY_EN
    par = 1'b1;
    extra = BITC;
`else
    par = 1'b0;
    extra = 0;
`endif
    rx    = 1'b1;
    RESET = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", int'(rx_data), 8'h00);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_parity_err", int'(parity_err), 0);
    check("reset_rx_busy", int'(rx_busy), 0);
    RESET = 1'b0;
    idle(5);

    // Good frame 0xA5 (4 ones -> even parity bit 0).
    expect_evt(K_VALID, 8'hA5, 0, LAT + extra);
    send_frame(8'hA5, 1'b1, par, 1'b0);
    idle(20);
    check("a5_rx_data", int'(rx_data), 8'hA5);
    check("a5_busy_after", int'(rx_busy), 0);

    // 3-clock glitch: rejected in START, no pulse expected.
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(3);
    check("glitch_busy_mid", int'(rx_busy), 1);
    idle(20);
    check("glitch_busy_after", int'(rx_busy), 0);

    // 0x3C with bad stop bit, then line stuck low.
    expect_evt(K_FERR, 8'hA5, 0, LAT + extra);
    send_frame(8'h3C, 1'b0, par, 1'b0);
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("break_busy_waithigh", int'(rx_busy), 1);
    check("break_rx_data_held", int'(rx_data), 8'hA5);
    idle(20);
    check("break_busy_released", int'(rx_busy), 0);
    expect_evt(K_VALID, 8'h55, 0, LAT + extra);
    send_frame(8'h55, 1'b1, par, 1'b0);
    idle(20);
    check("after_break_rx_data", int'(rx_data), 8'h55);

    // Back-to-back 0x00 then 0xFF with no idle gap.
    expect_evt(K_VALID, 8'h00, 0, LAT + extra);
    expect_evt(K_VALID, 8'hFF, 100 + extra, LAT + extra);
    send_frame(8'h00, 1'b1, par, 1'b0);
    send_frame(8'hFF, 1'b1, par, 1'b0);
    idle(20);
    check("b2b_rx_data", int'(rx_data), 8'hFF);

    // Reset in the middle of data bit 4 of 0xC3.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midframe_busy_before_reset", int'(rx_busy), 1);
    rx    = 1'b1;
    RESET = 1'b1;
    #1;
    check("midreset_rx_data", int'(rx_data), 8'h00);
    check("midreset_rx_busy", int'(rx_busy), 0);
    check("midreset_rx_valid", int'(rx_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    RESET = 1'b0;
    idle(30);
    check("after_reset_busy", int'(rx_busy), 0);
    expect_evt(K_VALID, 8'h81, 0, LAT + extra);
    send_frame(8'h81, 1'b1, par, 1'b0);
    idle(20);
    check("post_reset_rx_data", int'(rx_data), 8'h81);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: parity bit 1 is correct, 0 is a mismatch.
    expect_evt(K_VALID, 8'h07, 0, LAT + extra);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    idle(20);
    expect_evt(K_PERR, 8'h07, 0, LAT + extra);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    idle(20);
    check("parity_rx_data_held", int'(rx_data), 8'h07);
`endif

    for (int i = 0; i < 500 && q.size() != 0; i++) @(posedge clk);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_pulse: got nothing, expected kind %0d data %0h", e.kind, e.data);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
